// File: rtl/sd_dma_pkg.sv
// Shared definitions for the SD DMA engine and its memory-side responder:
// responder FSM states, error-flag bit positions and the SD block size.
package sd_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_R,
        ST_ACK,
        ST_HOLD
    } resp_state_e;

    localparam int ERR_MISALIGN = 0;
    localparam int ERR_RANGE    = 1;
    localparam int ERR_TIMEOUT  = 2;
    localparam int ERR_RW_BOTH  = 3;
    localparam int ERR_W        = 4;

    localparam int SD_BLOCK_WORDS = 128;

endpackage

// File: rtl/sd_dma_mem_responder.sv
// Memory-side responder for the SD DMA word interface: turns level-held DMA
// requests into single 32-bit accesses on an arbitrated RAM port.
module sd_dma_mem_responder
    import sd_dma_pkg::*;
#(
    parameter int ADDR_W      = 14,
    parameter int HOLD_CYCLES = 1,
    parameter int TIMEOUT     = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       mem_request_addr,
    input  logic [31:0]       mem_request_data,
    input  logic              mem_request_read,
    input  logic              mem_request_write,
    output logic              mem_ready_set,
    output logic [31:0]       mem_data_in,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic              ram_gnt,
    input  logic              ram_rvalid,
    input  logic [31:0]       ram_rdata,
    input  logic              err_clear,
    output logic [ERR_W-1:0]  err_flags,
    output logic [31:0]       beat_count
);

    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [3:0]  HOLD_LAST = 4'(HOLD_CYCLES - 1);

    resp_state_e       state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [15:0]       tmo_q, tmo_d;
    logic [3:0]        hold_q, hold_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [31:0]       beat_q, beat_d;

    logic req_any, req_both, req_misaligned, req_out_of_range;

    assign req_any          = mem_request_read | mem_request_write;
    assign req_both         = mem_request_read & mem_request_write;
    assign req_misaligned   = mem_request_addr[1:0] != 2'b00;
    assign req_out_of_range = (mem_request_addr >> (ADDR_W + 2)) != 32'd0;

    // NOTE: every _d gets its hold value first so no path through the case
    // below can leave a variable unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        tmo_d   = tmo_q;
        hold_d  = hold_q;
        beat_d  = beat_q;
        err_d   = err_clear ? '0 : err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_both) begin
                    err_d[ERR_RW_BOTH] = 1'b1;
                end else if (req_any) begin
                    if (req_misaligned)   err_d[ERR_MISALIGN] = 1'b1;
                    if (req_out_of_range) err_d[ERR_RANGE]    = 1'b1;
                    if (!req_misaligned && !req_out_of_range) begin
                        we_d    = mem_request_write;
                        addr_d  = mem_request_addr[ADDR_W+1:2];
                        wdata_d = mem_request_data;
                        tmo_d   = '0;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                tmo_d = tmo_q + 16'd1;
                if (ram_gnt) begin
                    state_d = we_q ? ST_ACK : ST_WAIT_R;
                end else if (tmo_q >= TMO_LAST) begin
                    err_d[ERR_TIMEOUT] = 1'b1;
                    state_d            = ST_IDLE;
                end
            end
            ST_WAIT_R: begin
                tmo_d = tmo_q + 16'd1;
                if (ram_rvalid) begin
                    rdata_d = ram_rdata;
                    state_d = ST_ACK;
                end else if (tmo_q >= TMO_LAST) begin
                    err_d[ERR_TIMEOUT] = 1'b1;
                    state_d            = ST_IDLE;
                end
            end
            ST_ACK: begin
                beat_d  = beat_q + 32'd1;
                hold_d  = '0;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                // Keeps the sampler blind while the DMA advances its address.
                if (hold_q == HOLD_LAST) state_d = ST_IDLE;
                else                     hold_d  = hold_q + 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them
    // update together from the values of the previous cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            tmo_q   <= '0;
            hold_q  <= '0;
            err_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            tmo_q   <= tmo_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
            beat_q  <= beat_d;
        end
    end

    assign ram_req       = state_q == ST_REQ;
    assign ram_we        = ram_req & we_q;
    assign ram_addr      = addr_q;
    assign ram_wdata     = wdata_q;
    assign mem_ready_set = state_q == ST_ACK;
    assign mem_data_in   = rdata_q;
    assign err_flags     = err_q;
    assign beat_count    = beat_q;

endmodule

// File: doc/sd_dma_mem_responder.md
Name: sd_dma_mem_responder

Overview:
- Memory-side responder for the SD DMA engine's word request interface.
- Accepts level-held read/write requests (address, data, direction) and performs one 32-bit RAM access per request on an arbitrated RAM port.
- Returns read data and pulses a one-cycle ready/ack back to the DMA.
- Sits between the DMA controller and the RAM arbiter; flags malformed or stuck requests as sticky errors.

Parameters:
- ADDR_W, 14, RAM word-address width; valid byte addresses are 0 .. 4*2^ADDR_W-1.
- HOLD_CYCLES, 1, idle cycles after each ack before the request lines are sampled again (range 1..15).
- TIMEOUT, 1024, max cycles spent in REQ plus WAIT_R before a timeout error (range 2..65535).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- mem_request_addr  in  32  byte address from DMA
- mem_request_data  in  32  write data from DMA
- mem_request_read  in  1  level; DMA wants a RAM read (RAM->SD)
- mem_request_write  in  1  level; DMA wants a RAM write (SD->RAM)
- mem_ready_set  out  1  one-cycle ack to DMA
- mem_data_in  out  32  read data to DMA; valid from the ack cycle until the next read completes
- ram_req  out  1  RAM access request, held until ram_gnt
- ram_we  out  1  1=write, 0=read; valid while ram_req=1
- ram_addr  out  ADDR_W  word address = mem_request_addr[ADDR_W+1:2]
- ram_wdata  out  32  write data
- ram_gnt  in  1  arbiter grant; accepts the access in that cycle
- ram_rvalid  in  1  read data valid, 1+ cycles after a read grant
- ram_rdata  in  32  read data
- err_clear  in  1  clears err_flags
- err_flags  out  4  sticky: [0] misaligned, [1] out of range, [2] timeout, [3] read and write both asserted
- beat_count  out  32  successful acks since reset, wraps at 2^32

Behaviour:
- Reset state: IDLE. All outputs are 0, including mem_data_in, err_flags and beat_count.
- Reset mid-operation aborts the access and drops ram_req immediately.
- A stray ram_rvalid after reset is ignored.

States: IDLE, REQ, WAIT_R, ACK, HOLD.

- IDLE: samples the request lines each cycle.
  - Neither line asserted: stay in IDLE.
  - Read and write both asserted: set err[3], stay in IDLE, no ack.
  - addr[1:0] != 0: set err[0], no ack, no RAM access, stay in IDLE.
  - addr[31:ADDR_W+2] != 0: set err[1], same treatment.
  - Otherwise: register addr, data and direction, then go to REQ.
  - The registered copy is used; later changes on the inputs are ignored.
  - Error conditions re-set their flag on every cycle they persist.
- REQ: ram_req=1, with ram_we/ram_addr/ram_wdata from the registers.
  - On ram_gnt, a write goes to ACK and a read goes to WAIT_R.
  - ram_req drops in the cycle after the grant.
- WAIT_R: on ram_rvalid, capture ram_rdata into mem_data_in, then go to ACK.
- ACK: mem_ready_set=1 for exactly one cycle; beat_count+1; then go to HOLD.
- HOLD: count HOLD_CYCLES cycles, then go to IDLE. This gives the DMA time to advance its address after the ack so a request is never serviced twice.
- Latency, write with immediate grant: request seen in cycle 0, ram_req in cycle 1, ack in cycle 2.
- Latency, read: ack in the cycle after ram_rvalid.
- Timeout: a 16-bit counter clears on entry to REQ and runs through REQ and WAIT_R.
  - On reaching TIMEOUT: set err[2], drop ram_req, go to IDLE with no ack. The DMA stays stalled, which is intended.
- Request withdrawn while in REQ/WAIT_R (DMA reset): the access still completes and the ack is still issued; the DMA ignores it.
- err_clear clears all flags. If err_clear coincides with a new error event, the new error wins (flag set).
- The block never issues more than one outstanding RAM access.

Decomposition:
- Shared package sd_dma_pkg:
  - state enum for this FSM;
  - ERR_* bit index constants;
  - SD_BLOCK_WORDS=128, shared with the DMA controller.
- No sub-module is needed; a single module is natural. The timeout counter is inline.

Test Plan:
- Write, immediate grant: addr 0x1000, data 0xCAFEBABE, write=1, gnt tied high.
  - ram_we=1, ram_addr=0x400, ram_wdata=0xCAFEBABE.
  - mem_ready_set pulses exactly once, 2 cycles after the request; beat_count=1.
  - Request still held through HOLD produces no second ack until the HOLD period ends.
- Read with 3-cycle rvalid latency: addr 0x2000, ram_rdata=0x12345678.
  - Ack arrives in the cycle after rvalid; mem_data_in=0x12345678 and holds after the ack.
- Back-to-back beats: a DMA model advances addr by 4 after each ack, 128 beats from 0x2000.
  - 128 acks, last ram_addr=0x87F, beat_count=128, no duplicate addresses.
- Errors:
  - addr 0x1002 → err_flags=0001, no ram_req.
  - addr 0x0001_0000 with ADDR_W=14 → err[1] set.
  - read and write both high → err[3] set.
  - err_clear → 0000.
- Timeout: TIMEOUT=8, gnt held low.
  - err[2] set after 8 cycles in REQ, ram_req drops, no ack.
- Reset mid-read: assert rst in WAIT_R.
  - All outputs 0 asynchronously.
  - A later ram_rvalid causes no ack.
  - A fresh write completes normally.
